// File: rtl/twos_to_sign_mag_if.sv
// Handshake bundle for the two's-complement to sign-magnitude decoder.
// The slave modport is the decoder's view; the master modport is the producer/consumer view.
interface twos_to_sign_mag_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] A;
  logic             in_valid;
  logic             in_ready;
  logic             sign;
  logic [WIDTH-1:0] mag;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  A, in_valid, out_ready,
    output in_ready, sign, mag, out_valid
  );

  modport master (
    output A, in_valid, out_ready,
    input  in_ready, sign, mag, out_valid
  );
endinterface

// File: rtl/twos_to_sign_mag.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB first, WIDTH cycles per word.
// Define TWOS_TO_SIGN_MAG_SAT_EN to clamp the most negative input to magnitude 2^(WIDTH-1)-1.
module twos_to_sign_mag #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  twos_to_sign_mag_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef TWOS_TO_SIGN_MAG_SAT_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_MAG  = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] mag_next;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             seen_one;
  logic             mag_bit;
  logic             last_bit;

  // Negation by "copy up to and including the first 1, then invert" applied only to negative words.
  always_comb begin
    mag_bit  = sign_q ? (shreg[0] ^ seen_one) : shreg[0];
    mag_next = {mag_bit, mag_q[WIDTH-1:1]};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid)  next_state = SHIFT;
      SHIFT:   if (last_bit)      next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      mag_q    <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      seen_one <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shreg    <= bus.A;
            sign_q   <= bus.A[WIDTH-1];
            seen_one <= 1'b0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          shreg    <= shreg >> 1;
          seen_one <= seen_one | shreg[0];
          cnt      <= cnt + CNT_W'(1);
          mag_q    <= mag_next;
`ifdef TWOS_TO_SIGN_MAG_SAT_EN
          // Only -2^(WIDTH-1) decodes to a negative word whose magnitude is MSB-only.
          if (last_bit && sign_q && (mag_next == MOST_NEG))
            mag_q <= SAT_MAG;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sign      = sign_q;
  assign bus.mag       = mag_q;
endmodule

// File: tb/tb_twos_to_sign_mag.sv
// Self-checking bench for twos_to_sign_mag at WIDTH=4: vector table, corner sequences,
// back-to-back stream and randomized words against an arithmetic reference model.
module tb_twos_to_sign_mag;
  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   total_checks;
  int   passed_checks;

  twos_to_sign_mag_if #(.WIDTH(WIDTH)) bus ();

  twos_to_sign_mag #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic       exp_sign;
    logic [3:0] exp_mag;
    int         stall;
  } vec_t;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_checks++;
    if (actual == expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference: plain signed arithmetic, absolute value, optional clamp.
  function automatic void ref_model(input logic [3:0] a, output logic s, output logic [3:0] m);
    int v;
    v = int'($signed(a));
    s = (v < 0);
    m = 4'(v < 0 ? -v : v);
`ifdef TWOS_TO_SIGN_MAG_SAT_EN
    if (v == -8) m = 4'd7;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds one word, waits for the result, optionally stalls the consumer, then completes the handshake.
  task automatic applyStimulus(input logic [3:0] a, input logic exp_s, input logic [3:0] exp_m,
                               input int stall, input string tag);
    int n;
    int lat;
    bus.out_ready = (stall == 0);
    bus.A         = a;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) checkOutput({tag, " in_ready timeout"}, 0, 1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    checkOutput({tag, " latency"}, lat, WIDTH);
    checkOutput({tag, " sign"}, int'(bus.sign), int'(exp_s));
    checkOutput({tag, " mag"}, int'(bus.mag), int'(exp_m));
    for (int i = 0; i < stall; i++) begin
      bus.A        = 4'($urandom);
      bus.in_valid = ~bus.in_valid;
      tick();
      checkOutput({tag, " stall out_valid"}, int'(bus.out_valid), 1);
      checkOutput({tag, " stall mag"}, int'(bus.mag), int'(exp_m));
      checkOutput({tag, " stall sign"}, int'(bus.sign), int'(exp_s));
      checkOutput({tag, " stall in_ready"}, int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    tick();
    checkOutput({tag, " out_valid drop"}, int'(bus.out_valid), 0);
    checkOutput({tag, " in_ready back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    vec_t       vecs[$];
    logic [3:0] q_mag[$];
    logic       q_sign[$];
    int         last_cyc;
    int         cyc;
    int         idx;
    int         got;
    logic       rs;
    logic [3:0] rm;
    logic [3:0] ra;
    int         seen_valid;

    total_checks  = 0;
    passed_checks = 0;
    bus.A         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    vecs.push_back('{4'b0101, 1'b0, 4'd5, 0});
    vecs.push_back('{4'b1011, 1'b1, 4'd5, 0});
    vecs.push_back('{4'b1111, 1'b1, 4'd1, 0});
    vecs.push_back('{4'b0000, 1'b0, 4'd0, 0});
`ifdef TWOS_TO_SIGN_MAG_SAT_EN
    vecs.push_back('{4'b1000, 1'b1, 4'd7, 0});
`else
    vecs.push_back('{4'b1000, 1'b1, 4'd8, 0});
`endif
    vecs.push_back('{4'b0111, 1'b0, 4'd7, 0});
    vecs.push_back('{4'b1001, 1'b1, 4'd7, 2});
    vecs.push_back('{4'b1110, 1'b1, 4'd2, 10});

    rst_n = 1'b0;
    #12;
    checkOutput("reset in_ready", int'(bus.in_ready), 1);
    checkOutput("reset out_valid", int'(bus.out_valid), 0);
    checkOutput("reset sign", int'(bus.sign), 0);
    checkOutput("reset mag", int'(bus.mag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].a, vecs[i].exp_sign, vecs[i].exp_mag, vecs[i].stall,
                    $sformatf("vec%0d", i));

    // Reset during the SHIFT phase must abort the word without an output pulse.
    bus.A        = 4'b1001;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("abort in_ready", int'(bus.in_ready), 1);
    checkOutput("abort out_valid", int'(bus.out_valid), 0);
    checkOutput("abort sign", int'(bus.sign), 0);
    checkOutput("abort mag", int'(bus.mag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) seen_valid++;
    end
    checkOutput("abort no out_valid", seen_valid, 0);
    applyStimulus(4'b0011, 1'b0, 4'd3, 0, "post-abort");

    // Back-to-back stream -7..7 with both handshakes held high.
    idx      = 0;
    got      = 0;
    cyc      = 0;
    last_cyc = -1;
    bus.out_ready = 1'b1;
    while (got < 15 && cyc < 300) begin
      if (bus.out_valid) begin
        if (q_mag.size() == 0) begin
          checkOutput("stream unexpected out_valid", 1, 0);
        end else begin
          checkOutput($sformatf("stream%0d sign", got), int'(bus.sign), int'(q_sign[0]));
          checkOutput($sformatf("stream%0d mag", got), int'(bus.mag), int'(q_mag[0]));
          void'(q_sign.pop_front());
          void'(q_mag.pop_front());
        end
        if (last_cyc >= 0) checkOutput($sformatf("stream%0d spacing", got), cyc - last_cyc, WIDTH + 2);
        last_cyc = cyc;
        got++;
      end
      if (bus.in_ready) begin
        if (idx < 15) begin
          ra = 4'(idx - 7);
          ref_model(ra, rs, rm);
          bus.A        = ra;
          bus.in_valid = 1'b1;
          q_sign.push_back(rs);
          q_mag.push_back(rm);
          idx++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    checkOutput("stream words received", got, 15);
    tick();
    tick();

    // Randomized words with random consumer backpressure.
    for (int i = 0; i < 30; i++) begin
      ra = 4'($urandom);
      ref_model(ra, rs, rm);
      applyStimulus(ra, rs, rm, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end
endmodule
